// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D memory-port arbiter: FSM encoding, access masks, requester ids.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b10;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // A load/store that asks for both directions at once is rejected without touching memory.
  function automatic logic d_req_illegal(input logic rd, input logic wr);
    return rd & wr;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the instruction, load/store and memory-side handshakes of the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_good;
  logic              i_err;
  logic [DATA_W-1:0] i_rdata;

  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_read;
  logic              d_write;
  logic [1:0]        d_mask;
  logic              d_sext;
  logic              d_good;
  logic              d_err;
  logic [DATA_W-1:0] d_rdata;

  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_read;
  logic              m_write;
  logic [1:0]        m_mask;
  logic              m_sext;
  logic              m_good;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_valid, i_addr,
    output i_good, i_err, i_rdata,
    input  d_valid, d_addr, d_wdata, d_read, d_write, d_mask, d_sext,
    output d_good, d_err, d_rdata,
    output m_valid, m_addr, m_wdata, m_read, m_write, m_mask, m_sext,
    input  m_good, m_rdata
  );

  modport master (
    output i_valid, i_addr,
    input  i_good, i_err, i_rdata,
    output d_valid, d_addr, d_wdata, d_read, d_write, d_mask, d_sext,
    input  d_good, d_err, d_rdata,
    input  m_valid, m_addr, m_wdata, m_read, m_write, m_mask, m_sext,
    output m_good, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: on contention the requester that was not granted last wins.
module mem_port_arbiter_rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant selection
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == REQ_I) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D) with round-robin
// grant, registered request/response paths and a per-access timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  arb_state_e        state_r, state_s;
  logic              last_grant_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic [1:0]        arb_grant_s;
  logic              busy_s, grant_i_s, grant_d_s, reject_d_s, done_s, timeout_s;

  logic              m_valid_r, m_read_r, m_write_r, m_sext_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [DATA_W-1:0] m_wdata_r;
  logic [1:0]        m_mask_r;
  logic              i_good_r, i_err_r, d_good_r, d_err_r;
  logic [DATA_W-1:0] i_rdata_r, d_rdata_r;

  assign busy_s = (state_r == ST_BUSY_I) || (state_r == ST_BUSY_D);

  mem_port_arbiter_rr_arb2 u_rr (
    .req   ({bus.d_valid, bus.i_valid}),
    .last  (last_grant_r),
    .grant (arb_grant_s)
  );

  // Next-state decode and per-cycle event strobes
  always_comb begin
    state_s    = state_r;
    grant_i_s  = 1'b0;
    grant_d_s  = 1'b0;
    reject_d_s = 1'b0;
    done_s     = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arb_grant_s[REQ_D]) begin
          if (d_req_illegal(bus.d_read, bus.d_write)) begin
            reject_d_s = 1'b1;
            state_s    = ST_RESP;
          end else begin
            grant_d_s = 1'b1;
            state_s   = ST_BUSY_D;
          end
        end else if (arb_grant_s[REQ_I]) begin
          grant_i_s = 1'b1;
          state_s   = ST_BUSY_I;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (bus.m_good) begin
          done_s  = 1'b1;
          state_s = ST_RESP;
        end else if (tmo_cnt_r == TMO_LAST) begin
          timeout_s = 1'b1;
          state_s   = ST_RESP;
        end else begin
          state_s = state_r;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, fairness pointer and timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= REQ_I;
      tmo_cnt_r    <= '0;
    end else begin
      state_r <= state_s;
      if (grant_i_s) begin
        last_grant_r <= REQ_I;
      end else if (grant_d_s) begin
        last_grant_r <= REQ_D;
      end
      if (busy_s && !done_s && !timeout_s) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end else begin
        tmo_cnt_r <= '0;
      end
    end
  end

  // Memory request register: loaded on grant, cleared when the access ends
  always_ff @(posedge clk) begin
    if (reset || ((done_s || timeout_s) && !grant_i_s && !grant_d_s)) begin
      m_valid_r <= 1'b0;
      m_addr_r  <= '0;
      m_wdata_r <= '0;
      m_read_r  <= 1'b0;
      m_write_r <= 1'b0;
      m_mask_r  <= MASK_B;
      m_sext_r  <= 1'b0;
    end else if (grant_i_s) begin
      m_valid_r <= 1'b1;
      m_addr_r  <= bus.i_addr;
      m_wdata_r <= '0;
      m_read_r  <= 1'b1;
      m_write_r <= 1'b0;
      m_mask_r  <= MASK_W;
      m_sext_r  <= 1'b0;
    end else if (grant_d_s) begin
      m_valid_r <= 1'b1;
      m_addr_r  <= bus.d_addr;
      m_wdata_r <= bus.d_wdata;
      m_read_r  <= bus.d_read;
      m_write_r <= bus.d_write;
      m_mask_r  <= bus.d_mask;
      m_sext_r  <= bus.d_sext;
    end
  end

  // Response pulses and read-data capture; stores report zero data
  always_ff @(posedge clk) begin
    if (reset) begin
      i_good_r  <= 1'b0;
      i_err_r   <= 1'b0;
      d_good_r  <= 1'b0;
      d_err_r   <= 1'b0;
      i_rdata_r <= '0;
      d_rdata_r <= '0;
    end else begin
      i_good_r <= done_s && (state_r == ST_BUSY_I);
      i_err_r  <= timeout_s && (state_r == ST_BUSY_I);
      d_good_r <= done_s && (state_r == ST_BUSY_D);
      d_err_r  <= (timeout_s && (state_r == ST_BUSY_D)) || reject_d_s;
      if (done_s && (state_r == ST_BUSY_I)) begin
        i_rdata_r <= bus.m_rdata;
      end
      if (done_s && (state_r == ST_BUSY_D)) begin
        d_rdata_r <= m_read_r ? bus.m_rdata : '0;
      end else if (reject_d_s) begin
        d_rdata_r <= '0;
      end
    end
  end

  assign bus.m_valid = m_valid_r;
  assign bus.m_addr  = m_addr_r;
  assign bus.m_wdata = m_wdata_r;
  assign bus.m_read  = m_read_r;
  assign bus.m_write = m_write_r;
  assign bus.m_mask  = m_mask_r;
  assign bus.m_sext  = m_sext_r;
  assign bus.i_good  = i_good_r;
  assign bus.i_err   = i_err_r;
  assign bus.i_rdata = i_rdata_r;
  assign bus.d_good  = d_good_r;
  assign bus.d_err   = d_err_r;
  assign bus.d_rdata = d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.i_valid = 1'b0;  bus.i_addr  = 32'h0;
    bus.d_valid = 1'b0;  bus.d_addr  = 32'h0;  bus.d_wdata = 32'h0;
    bus.d_read  = 1'b0;  bus.d_write = 1'b0;   bus.d_mask  = MASK_W;  bus.d_sext = 1'b0;
    bus.m_good  = 1'b0;  bus.m_rdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.m_good = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.m_valid, bus.i_good, bus.i_err, bus.d_good, bus.d_err} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b expected 00000",
                      {bus.m_valid, bus.i_good, bus.i_err, bus.d_good, bus.d_err});
    end
    total++;
    if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.i_rdata, bus.d_rdata);
    end
    total++;
    if ({bus.m_addr, bus.m_read, bus.m_write} !== 34'h0) begin
      bad++; $display("FAIL reset_mreq: got addr %h rd %b wr %b expected 0", bus.m_addr, bus.m_read, bus.m_write);
    end
    reset = 1'b0;
    bus.m_good = 1'b0;
  endtask

  task automatic test_i_read();
    bus.i_valid = 1'b1; bus.i_addr = 32'h10;
    bus.m_good = 1'b1; bus.m_rdata = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if ({bus.m_valid, bus.m_addr, bus.m_read, bus.m_write, bus.m_mask, bus.m_sext, bus.i_good} !==
        {1'b1, 32'h10, 1'b1, 1'b0, MASK_W, 1'b0, 1'b0}) begin
      bad++; $display("FAIL i_read_req: got v%b a%h r%b w%b m%b s%b g%b expected v1 a10 r1 w0 m10 s0 g0",
                      bus.m_valid, bus.m_addr, bus.m_read, bus.m_write, bus.m_mask, bus.m_sext, bus.i_good);
    end
    @(negedge clk);
    total++;
    if (bus.i_good !== 1'b1 || bus.i_rdata !== 32'hDEADBEEF || bus.i_err !== 1'b0 || bus.m_valid !== 1'b0) begin
      bad++; $display("FAIL i_read_resp: got g%b e%b d%h mv%b expected g1 e0 deadbeef mv0",
                      bus.i_good, bus.i_err, bus.i_rdata, bus.m_valid);
    end
    bus.i_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.i_good !== 1'b0 || bus.m_valid !== 1'b0) begin
      bad++; $display("FAIL i_read_pulse: got g%b mv%b expected g0 mv0", bus.i_good, bus.m_valid);
    end
    bus.m_good = 1'b0;
  endtask

  task automatic test_round_robin();
    bus.i_valid = 1'b1; bus.i_addr = 32'h100;
    bus.d_valid = 1'b1; bus.d_addr = 32'h200; bus.d_read = 1'b1; bus.d_write = 1'b0; bus.d_mask = MASK_W;
    bus.m_good = 1'b1; bus.m_rdata = 32'hA5A50001;
    @(negedge clk);
    total++;
    if (bus.m_valid !== 1'b1 || bus.m_addr !== 32'h200) begin
      bad++; $display("FAIL rr_first_d: got v%b a%h expected v1 a00000200", bus.m_valid, bus.m_addr);
    end
    @(negedge clk);
    total++;
    if (bus.d_good !== 1'b1 || bus.d_rdata !== 32'hA5A50001 || bus.i_good !== 1'b0) begin
      bad++; $display("FAIL rr_first_d_resp: got dg%b d%h ig%b expected dg1 a5a50001 ig0",
                      bus.d_good, bus.d_rdata, bus.i_good);
    end
    bus.d_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.m_valid !== 1'b1 || bus.m_addr !== 32'h100 || bus.m_mask !== MASK_W || bus.m_read !== 1'b1) begin
      bad++; $display("FAIL rr_then_i: got v%b a%h m%b r%b expected v1 a00000100 m10 r1",
                      bus.m_valid, bus.m_addr, bus.m_mask, bus.m_read);
    end
    bus.d_valid = 1'b1; bus.d_addr = 32'h204; bus.m_rdata = 32'hA5A50002;
    @(negedge clk);
    total++;
    if (bus.i_good !== 1'b1 || bus.i_rdata !== 32'hA5A50002) begin
      bad++; $display("FAIL rr_i_resp: got g%b d%h expected g1 a5a50002", bus.i_good, bus.i_rdata);
    end
    bus.i_addr = 32'h104; bus.m_rdata = 32'hA5A50003;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.m_valid !== 1'b1 || bus.m_addr !== 32'h204) begin
      bad++; $display("FAIL rr_d_after_i: got v%b a%h expected v1 a00000204", bus.m_valid, bus.m_addr);
    end
    @(negedge clk);
    total++;
    if (bus.d_good !== 1'b1 || bus.d_rdata !== 32'hA5A50003) begin
      bad++; $display("FAIL rr_d2_resp: got g%b d%h expected g1 a5a50003", bus.d_good, bus.d_rdata);
    end
    bus.d_addr = 32'h208; bus.m_rdata = 32'hA5A50004;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.m_valid !== 1'b1 || bus.m_addr !== 32'h104) begin
      bad++; $display("FAIL rr_i_after_d: got v%b a%h expected v1 a00000104", bus.m_valid, bus.m_addr);
    end
    @(negedge clk);
    total++;
    if (bus.i_good !== 1'b1 || bus.i_rdata !== 32'hA5A50004 || bus.d_good !== 1'b0) begin
      bad++; $display("FAIL rr_i2_resp: got ig%b d%h dg%b expected ig1 a5a50004 dg0",
                      bus.i_good, bus.i_rdata, bus.d_good);
    end
    bus.i_valid = 1'b0; bus.m_rdata = 32'hA5A50005;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.m_valid !== 1'b1 || bus.m_addr !== 32'h208) begin
      bad++; $display("FAIL rr_last_d: got v%b a%h expected v1 a00000208", bus.m_valid, bus.m_addr);
    end
    @(negedge clk);
    total++;
    if (bus.d_good !== 1'b1 || bus.d_rdata !== 32'hA5A50005) begin
      bad++; $display("FAIL rr_last_d_resp: got g%b d%h expected g1 a5a50005", bus.d_good, bus.d_rdata);
    end
    bus.d_valid = 1'b0;
    @(negedge clk);
    bus.m_good = 1'b0;
  endtask

  task automatic test_d_store();
    int held = 0;
    bus.d_valid = 1'b1; bus.d_addr = 32'h21; bus.d_wdata = 32'hAB;
    bus.d_read = 1'b0; bus.d_write = 1'b1; bus.d_mask = MASK_B; bus.d_sext = 1'b0;
    bus.m_good = 1'b0; bus.m_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.m_valid === 1'b1 && bus.m_addr === 32'h21 && bus.m_mask === MASK_B &&
          bus.m_write === 1'b1 && bus.m_read === 1'b0 && bus.m_wdata === 32'hAB) held++;
      if (c == 2) bus.m_good = 1'b1;
    end
    total++;
    if (held != 3) begin
      bad++; $display("FAIL store_req_held: got %0d cycles expected 3", held);
    end
    @(negedge clk);
    total++;
    if (bus.d_good !== 1'b1 || bus.d_rdata !== 32'h0 || bus.d_err !== 1'b0 || bus.m_valid !== 1'b0) begin
      bad++; $display("FAIL store_resp: got g%b e%b d%h mv%b expected g1 e0 0 mv0",
                      bus.d_good, bus.d_err, bus.d_rdata, bus.m_valid);
    end
    bus.d_valid = 1'b0; bus.m_good = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal_d();
    int mv = 0; int errs = 0; int goods = 0;
    bus.d_valid = 1'b1; bus.d_addr = 32'h44; bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_mask = MASK_W;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.m_valid === 1'b1) mv++;
      if (bus.d_err === 1'b1) errs++;
      if (bus.d_good === 1'b1) goods++;
      if (errs > 0) bus.d_valid = 1'b0;
    end
    total++;
    if (mv != 0 || errs != 1 || goods != 0) begin
      bad++; $display("FAIL illegal_d: got mv=%0d err=%0d good=%0d expected 0 1 0", mv, errs, goods);
    end
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_valid = 1'b0;
  endtask

  task automatic test_timeout();
    int mv = 0; int errs = 0; int goods = 0; int err_at = -1;
    bus.i_valid = 1'b1; bus.i_addr = 32'h400; bus.m_good = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.m_valid === 1'b1) mv++;
      if (bus.i_good === 1'b1) goods++;
      if (bus.i_err === 1'b1) begin
        errs++; err_at = c; bus.i_valid = 1'b0;
      end
    end
    total++;
    if (mv != TMO) begin
      bad++; $display("FAIL timeout_mvalid_cycles: got %0d expected %0d", mv, TMO);
    end
    total++;
    if (errs != 1 || goods != 0 || err_at != TMO) begin
      bad++; $display("FAIL timeout_err: got err=%0d good=%0d at=%0d expected 1 0 %0d", errs, goods, err_at, TMO);
    end
    total++;
    if (bus.m_valid !== 1'b0 || bus.i_err !== 1'b0) begin
      bad++; $display("FAIL timeout_idle: got mv%b e%b expected mv0 e0", bus.m_valid, bus.i_err);
    end
  endtask

  task automatic test_reset_mid_access();
    bus.d_valid = 1'b1; bus.d_addr = 32'h500; bus.d_read = 1'b1; bus.d_write = 1'b0;
    bus.d_mask = MASK_H; bus.d_sext = 1'b1; bus.m_good = 1'b0;
    @(negedge clk);
    total++;
    if (bus.m_valid !== 1'b1 || bus.m_addr !== 32'h500 || bus.m_mask !== MASK_H || bus.m_sext !== 1'b1) begin
      bad++; $display("FAIL rst_mid_busy: got v%b a%h m%b s%b expected v1 a00000500 m01 s1",
                      bus.m_valid, bus.m_addr, bus.m_mask, bus.m_sext);
    end
    reset = 1'b1; bus.d_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.m_valid !== 1'b0 || bus.d_good !== 1'b0 || bus.d_err !== 1'b0) begin
      bad++; $display("FAIL rst_mid_drop: got mv%b g%b e%b expected 0 0 0", bus.m_valid, bus.d_good, bus.d_err);
    end
    reset = 1'b0;
    bus.m_good = 1'b1; bus.m_rdata = 32'h12345678;
    bus.i_valid = 1'b1; bus.i_addr = 32'h300;
    @(negedge clk);
    total++;
    if (bus.m_valid !== 1'b1 || bus.m_addr !== 32'h300 || bus.d_good !== 1'b0) begin
      bad++; $display("FAIL rst_mid_i_req: got v%b a%h dg%b expected v1 a00000300 dg0",
                      bus.m_valid, bus.m_addr, bus.d_good);
    end
    @(negedge clk);
    total++;
    if (bus.i_good !== 1'b1 || bus.i_rdata !== 32'h12345678 || bus.d_good !== 1'b0 || bus.d_err !== 1'b0) begin
      bad++; $display("FAIL rst_mid_i_resp: got ig%b d%h dg%b de%b expected ig1 12345678 dg0 de0",
                      bus.i_good, bus.i_rdata, bus.d_good, bus.d_err);
    end
    bus.i_valid = 1'b0; bus.m_good = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_round_robin();
    test_d_store();
    test_illegal_d();
    test_timeout();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
